// File: rtl/lpc_host_io_if.sv
// Signal bundle for lpc_host_io: SoC-side request/completion port plus the LPC pin signals.
interface lpc_host_io_if;
    logic        i_req;
    logic        i_wr;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_rdata;
    logic        o_lframe_n;
    logic [3:0]  o_lad_out;
    logic        o_lad_oe;
    logic [3:0]  i_lad_in;

    modport slave (
        input  i_req, i_wr, i_addr, i_wdata, i_lad_in,
        output o_busy, o_done, o_err, o_rdata, o_lframe_n, o_lad_out, o_lad_oe
    );

    modport master (
        output i_req, i_wr, i_addr, i_wdata, i_lad_in,
        input  o_busy, o_done, o_err, o_rdata, o_lframe_n, o_lad_out, o_lad_oe
    );
endinterface

// File: rtl/lpc_host_io.sv
// LPC host initiator for single I/O read/write cycles; pins are registered from the
// next-state decode so each pin value lines up with the state it belongs to.
module lpc_host_io #(
    parameter int unsigned NORESP_LIMIT = 3,
    parameter int unsigned SWAIT_LIMIT  = 8,
    parameter int unsigned LWAIT_LIMIT  = 1024
) (
    input logic          lpc_lclk,
    input logic          lpc_lreset,
    lpc_host_io_if.slave lpc
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CYCTYP, S_ADDR, S_WDATA, S_HTAR1, S_HTAR2,
        S_SYNC, S_RDATA, S_PTAR1, S_PTAR2, S_ABORT
    } state_e;

    typedef enum logic [1:0] {CLS_NONE, CLS_SWAIT, CLS_LWAIT, CLS_NORESP} cls_e;

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d, cls_s;
    logic [1:0]  cnt_q, cnt_d;
    logic [10:0] wait_q, wait_d, wait_s, lim_s;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        flag_q, flag_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        lframe_q, lframe_d;
    logic [3:0]  lad_q, lad_d;
    logic        oe_q, oe_d;

    always_ff @(posedge lpc_lclk) begin
        if (lpc_lreset) begin
            state_q  <= S_IDLE;
            cls_q    <= CLS_NONE;
            cnt_q    <= 2'd0;
            wait_q   <= 11'd0;
            wr_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            rbuf_q   <= 8'h00;
            rdata_q  <= 8'h00;
            flag_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lframe_q <= 1'b1;
            lad_q    <= 4'h0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            flag_q   <= flag_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lframe_q <= lframe_d;
            lad_q    <= lad_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Classify the SYNC sample; the wait run restarts whenever the class changes.
        if (lpc.i_lad_in == 4'b0101) begin
            cls_s = CLS_SWAIT;
            lim_s = 11'(SWAIT_LIMIT);
        end else if (lpc.i_lad_in == 4'b0110) begin
            cls_s = CLS_LWAIT;
            lim_s = 11'(LWAIT_LIMIT);
        end else begin
            cls_s = CLS_NORESP;
            lim_s = 11'(NORESP_LIMIT);
        end
        wait_s = (cls_s == cls_q) ? wait_q + 11'd1 : 11'd1;

        case (state_q)
            S_IDLE: begin
                if (lpc.i_req) begin
                    wr_d    = lpc.i_wr;
                    addr_d  = lpc.i_addr;
                    wdata_d = lpc.i_wdata;
                    flag_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START:  state_d = S_CYCTYP;
            S_CYCTYP: begin
                cnt_d   = 2'd0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = wr_q ? S_WDATA : S_HTAR1;
                end
            end
            S_WDATA: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = S_HTAR1;
                end
            end
            S_HTAR1: state_d = S_HTAR2;
            S_HTAR2: begin
                wait_d  = 11'd0;
                cls_d   = CLS_NONE;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                if (lpc.i_lad_in == 4'b0000 || lpc.i_lad_in == 4'b1010) begin
                    flag_d  = (lpc.i_lad_in == 4'b1010);
                    cnt_d   = 2'd0;
                    state_d = wr_q ? S_PTAR1 : S_RDATA;
                end else begin
                    wait_d = wait_s;
                    cls_d  = cls_s;
                    if (wait_s == lim_s) begin
                        cnt_d   = 2'd0;
                        state_d = S_ABORT;
                    end
                end
            end
            S_RDATA: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    rbuf_d = {rbuf_q[7:4], lpc.i_lad_in};
                end else begin
                    rbuf_d  = {lpc.i_lad_in, rbuf_q[3:0]};
                    cnt_d   = 2'd0;
                    state_d = S_PTAR1;
                end
            end
            S_PTAR1: state_d = S_PTAR2;
            S_PTAR2: begin
                done_d  = 1'b1;
                err_d   = flag_q;
                if (!wr_q) rdata_d = rbuf_q;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        lframe_d = 1'b1;
        lad_d    = 4'h0;
        oe_d     = 1'b0;
        case (state_d)
            S_START: begin
                lframe_d = 1'b0;
                oe_d     = 1'b1;
            end
            S_CYCTYP: begin
                lad_d = wr_d ? 4'b0010 : 4'b0000;
                oe_d  = 1'b1;
            end
            S_ADDR: begin
                oe_d = 1'b1;
                case (cnt_d)
                    2'd0:    lad_d = addr_d[15:12];
                    2'd1:    lad_d = addr_d[11:8];
                    2'd2:    lad_d = addr_d[7:4];
                    default: lad_d = addr_d[3:0];
                endcase
            end
            S_WDATA: begin
                oe_d  = 1'b1;
                lad_d = (cnt_d == 2'd0) ? wdata_d[3:0] : wdata_d[7:4];
            end
            S_HTAR1: begin
                lad_d = 4'hF;
                oe_d  = 1'b1;
            end
            S_ABORT: begin
                lframe_d = 1'b0;
                lad_d    = 4'hF;
                oe_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign lpc.o_busy     = (state_q != S_IDLE);
    assign lpc.o_done     = done_q;
    assign lpc.o_err      = err_q;
    assign lpc.o_rdata    = rdata_q;
    assign lpc.o_lframe_n = lframe_q;
    assign lpc.o_lad_out  = lad_q;
    assign lpc.o_lad_oe   = oe_q;
endmodule

// File: tb/tb_lpc_host_io.sv
// Bench for lpc_host_io: directed vector table, hand sequences for reset and chaining,
// and randomized transactions checked cycle by cycle against a transaction-level model.
module tb_lpc_host_io;
    logic clk = 1'b0;
    logic rst;
    always #15 clk = ~clk;

    lpc_host_io_if lpc();

    lpc_host_io #(.NORESP_LIMIT(3), .SWAIT_LIMIT(8), .LWAIT_LIMIT(1024)) dut (
        .lpc_lclk   (clk),
        .lpc_lreset (rst),
        .lpc        (lpc)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] last_rdata;
    logic [3:0] sync_q[$];

    typedef struct {
        logic       fr;
        logic       oe;
        logic [3:0] lad;
        logic [3:0] drv;
    } cyc_t;
    cyc_t tr[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        logic [31:0] seq;
        int          done_at;
        logic        err;
        logic [7:0]  rdata;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void push(input logic fr, input logic oe, input logic [3:0] lad,
                                 input logic [3:0] drv);
        cyc_t c;
        c.fr = fr; c.oe = oe; c.lad = lad; c.drv = drv;
        tr.push_back(c);
    endfunction

    // Expected pin trace of one transaction, derived from the cycle layout and SYNC rules.
    task automatic build_model(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] rd, output bit ab, output bit ef);
        int run, prev, cls, lim, n;
        bit decided;
        tr.delete();
        ab = 0; ef = 0; n = 0; run = 0; prev = -1; decided = 0;
        for (int i = 0; i < sync_q.size() && !decided; i++) begin
            n = i + 1;
            if (sync_q[i] == 4'h0 || sync_q[i] == 4'hA) begin
                ef = (sync_q[i] == 4'hA);
                decided = 1;
            end else begin
                cls = (sync_q[i] == 4'h5) ? 1 : (sync_q[i] == 4'h6) ? 2 : 3;
                run = (cls == prev) ? run + 1 : 1;
                prev = cls;
                lim = (cls == 1) ? 8 : (cls == 2) ? 1024 : 3;
                if (run == lim) begin
                    ab = 1;
                    decided = 1;
                end
            end
        end
        if (!decided) begin
            $display("FAIL model: got undecided SYNC sequence expected terminating code");
            $fatal(1, "bench stimulus error");
        end
        push(0, 1, 4'h0, 4'($urandom));
        push(1, 1, wr ? 4'h2 : 4'h0, 4'($urandom));
        for (int k = 0; k < 4; k++) push(1, 1, 4'(addr >> (12 - 4 * k)), 4'($urandom));
        if (wr) begin
            push(1, 1, wdata[3:0], 4'($urandom));
            push(1, 1, wdata[7:4], 4'($urandom));
        end
        push(1, 1, 4'hF, 4'($urandom));
        push(1, 0, 4'h0, 4'($urandom));
        for (int i = 0; i < n; i++) push(1, 0, 4'h0, sync_q[i]);
        if (ab) begin
            for (int k = 0; k < 4; k++) push(0, 1, 4'hF, 4'($urandom));
        end else begin
            if (!wr) begin
                push(1, 0, 4'h0, rd[3:0]);
                push(1, 0, 4'h0, rd[7:4]);
            end
            push(1, 0, 4'h0, 4'($urandom));
            push(1, 0, 4'h0, 4'($urandom));
        end
    endtask

    task automatic start_req(input logic wr, input logic [15:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        check("idle_before_req", {30'd0, lpc.o_busy, lpc.o_done}, 32'd0);
        lpc.i_wr    = wr;
        lpc.i_addr  = addr;
        lpc.i_wdata = wdata;
        lpc.i_req   = 1'b1;
    endtask

    // Runs one accepted transaction from its accept edge through the o_done cycle.
    task automatic run_txn(input logic [7:0] rd, input bit chain, input bit use_tbl,
                           input int exp_done, input logic exp_err, input logic [7:0] exp_rd);
        bit ab, ef;
        int done_at;
        logic [7:0] rexp;
        logic [3:0] lad_m, lad_e;
        build_model(lpc.i_wr, lpc.i_addr, lpc.i_wdata, rd, ab, ef);
        rexp = (!lpc.i_wr && !ab) ? rd : last_rdata;
        done_at = -1;
        @(posedge clk);
        for (int k = 0; k < tr.size(); k++) begin
            @(negedge clk);
            if (k == 0) lpc.i_req = 1'b0;
            if (lpc.o_done && done_at < 0) done_at = k + 1;
            lad_m = lpc.o_lad_oe ? lpc.o_lad_out : 4'h0;
            lad_e = tr[k].oe ? tr[k].lad : 4'h0;
            check($sformatf("cycle%0d_pins", k + 1),
                  {24'd0, lpc.o_busy, lpc.o_done, lpc.o_lframe_n, lpc.o_lad_oe, lad_m},
                  {24'd0, 1'b1, 1'b0, tr[k].fr, tr[k].oe, lad_e});
            lpc.i_lad_in = tr[k].drv;
        end
        @(negedge clk);
        if (lpc.o_done && done_at < 0) done_at = tr.size() + 1;
        check("done_cycle_outputs",
              {19'd0, lpc.o_busy, lpc.o_done, lpc.o_err, lpc.o_rdata, lpc.o_lframe_n, lpc.o_lad_oe},
              {19'd0, 1'b0, 1'b1, ab | ef, rexp, 1'b1, 1'b0});
        if (use_tbl) begin
            check("done_at_cycle", 32'(done_at), 32'(exp_done));
            check("tbl_err_rdata", {23'd0, lpc.o_err, lpc.o_rdata}, {23'd0, exp_err, exp_rd});
        end
        last_rdata = rexp;
        lpc.i_req = chain;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nseg, len;
        logic [3:0] code;

        vt[0] = '{1'b1, 16'h0080, 8'hA5, 8'h00, 32'h0000_0000, 14, 1'b0, 8'h00};
        vt[1] = '{1'b0, 16'h0060, 8'h00, 8'h3C, 32'h0000_0055, 16, 1'b0, 8'h3C};
        vt[2] = '{1'b1, 16'h1234, 8'h5A, 8'h00, 32'h0000_0FFF, 18, 1'b1, 8'h3C};
        vt[3] = '{1'b0, 16'h03F8, 8'h00, 8'h7E, 32'h0000_000A, 14, 1'b1, 8'h7E};
        vt[4] = '{1'b0, 16'hBEEF, 8'h00, 8'h11, 32'h5555_5555, 21, 1'b1, 8'h7E};
        vt[5] = '{1'b0, 16'h0042, 8'h00, 8'h91, 32'h0555_5555, 21, 1'b0, 8'h91};
        vt[6] = '{1'b1, 16'hFFFF, 8'h3C, 8'h00, 32'h000F_F5FF, 19, 1'b0, 8'h91};
        vt[7] = '{1'b1, 16'h0001, 8'hC3, 8'h00, 32'h0000_0066, 16, 1'b0, 8'h91};

        rst = 1'b1;
        lpc.i_req = 1'b0; lpc.i_wr = 1'b0; lpc.i_addr = 16'h0; lpc.i_wdata = 8'h0;
        lpc.i_lad_in = 4'hF;
        last_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state",
              {16'd0, lpc.o_busy, lpc.o_done, lpc.o_err, lpc.o_lframe_n, lpc.o_lad_oe,
               lpc.o_lad_out[2:0], lpc.o_rdata},
              {16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h00});
        check("reset_lad_msb", {31'd0, lpc.o_lad_out[3]}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            sync_q.delete();
            for (int j = 0; j < 8; j++) sync_q.push_back(4'(vt[i].seq >> (4 * j)));
            start_req(vt[i].wr, vt[i].addr, vt[i].wdata);
            run_txn(vt[i].rd, 0, 1, vt[i].done_at, vt[i].err, vt[i].rdata);
        end

        // Reset in the middle of the address phase, then a clean read.
        start_req(1'b0, 16'h002E, 8'h00);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) lpc.i_req = 1'b0;
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_txn",
              {18'd0, lpc.o_lframe_n, lpc.o_lad_oe, lpc.o_busy, lpc.o_done, lpc.o_lad_out, lpc.o_rdata},
              {18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
        last_rdata = 8'h00;
        @(negedge clk);
        check("reset_no_done", {30'd0, lpc.o_busy, lpc.o_done}, 32'd0);
        sync_q = '{4'h0};
        start_req(1'b0, 16'h002E, 8'h00);
        run_txn(8'h5A, 0, 1, 14, 1'b0, 8'h5A);

        // Back-to-back: request held high across the o_done cycle.
        sync_q = '{4'h0};
        start_req(1'b1, 16'h0080, 8'hA5);
        run_txn(8'h00, 1, 1, 14, 1'b0, 8'h5A);
        run_txn(8'h00, 0, 1, 14, 1'b0, 8'h5A);

        // Long-wait run one short of the limit, then exactly at the limit.
        sync_q.delete();
        repeat (1023) sync_q.push_back(4'h6);
        sync_q.push_back(4'h0);
        start_req(1'b0, 16'h0300, 8'h00);
        run_txn(8'hD2, 0, 1, 1037, 1'b0, 8'hD2);
        sync_q.delete();
        repeat (1024) sync_q.push_back(4'h6);
        start_req(1'b0, 16'h0301, 8'h00);
        run_txn(8'h4B, 0, 1, 1037, 1'b1, 8'hD2);

        for (int t = 0; t < 40; t++) begin
            sync_q.delete();
            nseg = $urandom_range(0, 3);
            for (int s = 0; s < nseg; s++) begin
                case ($urandom_range(0, 3))
                    0: begin code = 4'h5; len = $urandom_range(1, 9); end
                    1: begin code = 4'h6; len = $urandom_range(1, 4); end
                    2: begin code = 4'hF; len = $urandom_range(1, 4); end
                    default: begin code = 4'h3; len = $urandom_range(1, 4); end
                endcase
                repeat (len) sync_q.push_back(code);
            end
            sync_q.push_back(($urandom_range(0, 1) == 0) ? 4'h0 : 4'hA);
            start_req(1'($urandom), 16'($urandom), 8'($urandom));
            run_txn(8'($urandom), 0, 0, 0, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lpc_host_io.md
# lpc_host_io

LPC host-side initiator for I/O cycles: it turns a single-transaction request (address, direction, write byte) into a complete LPC I/O read or write on LAD[3:0]/LFRAME#. It samples the peripheral's SYNC and read data, and returns completion status. It sits between the SoC-side register/AHB bridge and the LPC pins, driving the same bus that our LPC peripheral block receives. LAD tri-stating is done at the top level from `o_lad_out`/`o_lad_oe`.

## Interface
Parameters:
- `NORESP_LIMIT`, 3: consecutive SYNC cycles with no valid code (any code except 0000/0101/0110/1010) before abort.
- `SWAIT_LIMIT`, 8: consecutive short-wait (0101) cycles before abort.
- `LWAIT_LIMIT`, 1024: consecutive long-wait (0110) cycles before abort.

Ports:
- `lpc_lclk` in 1: LPC clock, 33 MHz. Single clock domain; all logic on rising edge.
- `lpc_lreset` in 1: reset, synchronous, active-high.
- `i_req` in 1: transaction request; sampled only while `o_busy`=0.
- `i_wr` in 1: 1 = I/O write, 0 = I/O read. Latched on accept.
- `i_addr` in 16: I/O address. Latched on accept.
- `i_wdata` in 8: write byte. Latched on accept.
- `o_busy` out 1: a transaction is in progress.
- `o_done` out 1: one-cycle completion pulse.
- `o_err` out 1: valid with `o_done`; 1 = SYNC error (1010) or abort.
- `o_rdata` out 8: read byte, valid with `o_done` and held until the next accept.
- `o_lframe_n` out 1: LFRAME#, registered.
- `o_lad_out` out 4: LAD drive value, registered.
- `o_lad_oe` out 1: LAD output enable, registered.
- `i_lad_in` in 4: LAD pin sample.

## Operation
- States: IDLE, START, CYCTYP, ADDR (4 nibbles, 2-bit counter), WDATA (2 nibbles), HTAR1, HTAR2, SYNC, RDATA (2 nibbles), PTAR1, PTAR2, ABORT (4 cycles).
- IDLE: `o_lframe_n`=1, `o_lad_oe`=0. If `i_req`=1, latch inputs and go to START.
- START: `o_lframe_n`=0, LAD=0000, oe=1.
- CYCTYP: `o_lframe_n`=1, LAD=0000 for a read or 0010 for a write.
- ADDR: drives `i_addr[15:12]`, `[11:8]`, `[7:4]`, `[3:0]` in that order (MSB nibble first).
- Write path: CYCTYP → ADDR → WDATA (`wdata[3:0]`, then `[7:4]`) → HTAR1 → HTAR2 → SYNC.
- Read path: CYCTYP → ADDR → HTAR1 → HTAR2 → SYNC.
- HTAR1: LAD=1111, oe=1. HTAR2: oe=0. oe stays 0 through SYNC, RDATA and PTAR.
- SYNC: `i_lad_in` is sampled every cycle.
  - 0000: proceed; error flag cleared.
  - 1010: proceed; error flag set.
  - 0101 / 0110: remain in SYNC, counting toward the matching limit.
  - Anything else: remain in SYNC, counting toward `NORESP_LIMIT`.
  - The wait counter (11 bits) resets whenever the sampled code class changes.
  - Reaching a limit → ABORT.
  - After SYNC, a read goes to RDATA and a write goes to PTAR1.
- RDATA: first nibble → `rdata[3:0]`, second → `rdata[7:4]`. Then PTAR1 → PTAR2, with the peripheral's turnaround ignored.
- PTAR2 → IDLE. The first IDLE cycle asserts `o_done`, with `o_err` = error flag.
- ABORT: `o_lframe_n`=0, LAD=1111, oe=1 for exactly 4 cycles. Then IDLE with `o_done`=1, `o_err`=1; `o_rdata` is not updated.
- `o_busy`=1 in every non-IDLE state.
- A request may be accepted in the same IDLE cycle that pulses `o_done`.
- Reset values: `o_lframe_n`=1, `o_lad_out`=0000, `o_lad_oe`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_rdata`=0x00, state IDLE, all counters 0.
- Reset mid-transaction: return to IDLE on the next edge with all reset values; no `o_done`, no abort sequence.

## Timing
- Accept edge = E0. Pin values are listed per cycle *n* after E0.
- Common prefix: cycle 1 START; cycle 2 CYCTYP; cycles 3–6 ADDR.
- Write: cycles 7–8 WDATA; 9 HTAR1; 10 HTAR2; SYNC from 11.
- Read: 7 HTAR1; 8 HTAR2; SYNC from 9; two RDATA cycles after the accepted SYNC.
- With ready SYNC on the first SYNC cycle, `o_done` is at cycle 14 for both read and write. Each wait or invalid SYNC cycle adds 1.
- Abort: `o_done` appears 5 cycles after the cycle that reached the limit. Example with no response: SYNC cycles 11–13, ABORT 14–17, `o_done` 18 (write).
- Output change follows state by 0 cycles (pins registered from next-state decode). `i_lad_in` is sampled on the rising edge ending each cycle.

## Test plan
- Write 0x0080 ← 0xA5, peripheral SYNC 0000 at cycle 11 → LAD 0000, 0010, 0, 0, 8, 0, 5, A, F; `o_done`=1, `o_err`=0 at cycle 14.
- Read 0x0060, SYNC 0101, 0101, 0000 from cycle 9, data nibbles C then 3 → `o_rdata`=0x3C, `o_err`=0, `o_done` at cycle 16.
- Write with LAD held 1111 during SYNC → ABORT at cycles 14–17 (`o_lframe_n`=0, LAD=1111); `o_done`+`o_err` at 18.
- Read with SYNC 1010 then data 0x7E → `o_rdata`=0x7E, `o_err`=1, `o_done` at cycle 14.
- `lpc_lreset`=1 during ADDR cycle 4 → next cycle `o_lframe_n`=1, `o_lad_oe`=0, `o_busy`=0, no `o_done`. A new read is then accepted normally.
- Back-to-back: `i_req` held high → second START at cycle 15, one cycle after the first `o_done` at 14.
